// File: rtl/timer_capture.sv
// timer_capture: measures the clk-cycle interval between successive qualifying edges on evt_in
// and presents each period on a valid/ready output with overflow and overrun status.
//
// Parameters:
//   NBITS  - width of the period counter and cap_period
//   RISING - 1: rising edges of evt_in qualify; 0: falling edges qualify
//
// Ports:
//   clk         - single clock, all logic on the rising edge
//   reset       - asynchronous reset, active low
//   enable      - 1 = measure; 0 = abort the measurement and return to idle
//   evt_in      - event input
//   cap_ready   - consumer accepts the current sample
//   clr_overrun - synchronous clear of the sticky overrun flag
//   cap_valid   - a sample is held on cap_period/cap_ovf
//   cap_period  - clk cycles between the last two qualifying edges
//   cap_ovf     - sample saturated at 2^NBITS-1
//   overrun     - sticky: a sample was dropped because the held one was not taken
//   busy        - 1 while a period is being measured
//
// Build option: define CAPTURE_SYNC_EN to add a two-flop synchroniser in front of the edge
// detector for an asynchronous evt_in (latency +2 cycles, periods unchanged).

module timer_capture #(
    parameter int unsigned NBITS  = 32,
    parameter bit          RISING = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             evt_in,
    input  logic             cap_ready,
    input  logic             clr_overrun,
    output logic             cap_valid,
    output logic [NBITS-1:0] cap_period,
    output logic             cap_ovf,
    output logic             overrun,
    output logic             busy
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StArm  = 2'd1;
    localparam logic [1:0] StMeas = 2'd2;

    localparam logic [NBITS-1:0] CntMax = {NBITS{1'b1}};
    localparam logic [NBITS-1:0] CntOne = NBITS'(1);

    logic             evt_src;
    logic             evt_s_q, evt_d_q, evt_edge, evt_edge_q;
    logic [1:0]       state_d, state_q;
    logic [NBITS-1:0] cnt_d, cnt_q;
    logic             sat_d, sat_q;
    logic             capture;
    logic             cap_valid_d, cap_valid_q;
    logic [NBITS-1:0] cap_period_d, cap_period_q;
    logic             cap_ovf_d, cap_ovf_q;
    logic             overrun_d, overrun_q;
    logic             overrun_set;

`ifdef CAPTURE_SYNC_EN
    logic sync1_q, sync2_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= evt_in;
            sync2_q <= sync1_q;
        end
    end

    assign evt_src = sync2_q;
`else
    assign evt_src = evt_in;
`endif

    // Edge is registered once more so the FSM acts on it two clocks after evt_in is sampled.
    assign evt_edge = RISING ? (evt_s_q & ~evt_d_q) : (~evt_s_q & evt_d_q);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            evt_s_q    <= 1'b0;
            evt_d_q    <= 1'b0;
            evt_edge_q <= 1'b0;
        end else begin
            evt_s_q    <= evt_src;
            evt_d_q    <= evt_s_q;
            evt_edge_q <= evt_edge;
        end
    end

    // Measurement FSM and period counter.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sat_d   = sat_q;
        capture = 1'b0;
        case (state_q)
            StIdle: begin
                cnt_d = '0;
                sat_d = 1'b0;
                if (enable) state_d = StArm;
            end
            StArm: begin
                if (evt_edge_q) begin
                    state_d = StMeas;
                    cnt_d   = CntOne;
                    sat_d   = 1'b0;
                end
            end
            StMeas: begin
                if (evt_edge_q) begin
                    capture = 1'b1;
                    cnt_d   = CntOne;
                    sat_d   = 1'b0;
                end else if (cnt_q == CntMax) begin
                    // Counting past the top: the period no longer fits.
                    sat_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
            end
            default: state_d = StIdle;
        endcase
        // Abort wins over everything, discarding the in-flight period.
        if (!enable) begin
            state_d = StIdle;
            cnt_d   = '0;
            sat_d   = 1'b0;
            capture = 1'b0;
        end
    end

    // Output holding register with valid/ready handshake and overrun tracking.
    always_comb begin
        cap_valid_d  = cap_valid_q;
        cap_period_d = cap_period_q;
        cap_ovf_d    = cap_ovf_q;
        overrun_set  = 1'b0;
        if (capture) begin
            if (!cap_valid_q || cap_ready) begin
                cap_valid_d  = 1'b1;
                cap_period_d = cnt_q;
                cap_ovf_d    = sat_q;
            end else begin
                overrun_set = 1'b1;
            end
        end else if (cap_valid_q && cap_ready) begin
            cap_valid_d = 1'b0;
        end
        if (overrun_set) begin
            overrun_d = 1'b1;
        end else if (clr_overrun) begin
            overrun_d = 1'b0;
        end else begin
            overrun_d = overrun_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            sat_q        <= 1'b0;
            cap_valid_q  <= 1'b0;
            cap_period_q <= '0;
            cap_ovf_q    <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            sat_q        <= sat_d;
            cap_valid_q  <= cap_valid_d;
            cap_period_q <= cap_period_d;
            cap_ovf_q    <= cap_ovf_d;
            overrun_q    <= overrun_d;
        end
    end

    assign cap_valid  = cap_valid_q;
    assign cap_period = cap_period_q;
    assign cap_ovf    = cap_ovf_q;
    assign overrun    = overrun_q;
    assign busy       = (state_q == StMeas);

endmodule

// File: tb/tb_timer_capture.sv
// Directed bench for timer_capture: a 32-bit rising-edge instance, a 4-bit rising-edge instance
// and a 32-bit falling-edge instance share one stimulus stream.
module tb_timer_capture;

`ifdef CAPTURE_SYNC_EN
    localparam int OFF = 5;  // cycles from driving evt_in high to cap_valid
`else
    localparam int OFF = 3;
`endif

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic        evt_in;
    logic        cap_ready;
    logic        clr_overrun;

    logic        v32, ovf32, ovr32, busy32;
    logic [31:0] p32;
    logic        v4, ovf4, ovr4, busy4;
    logic [3:0]  p4;
    logic        vf, ovff, ovrf, busyf;
    logic [31:0] pf;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int t_edge = 0;

    timer_capture #(.NBITS(32), .RISING(1'b1)) u_dut32 (
        .clk(clk), .reset(rst_n), .enable(enable), .evt_in(evt_in), .cap_ready(cap_ready),
        .clr_overrun(clr_overrun), .cap_valid(v32), .cap_period(p32), .cap_ovf(ovf32),
        .overrun(ovr32), .busy(busy32)
    );

    timer_capture #(.NBITS(4), .RISING(1'b1)) u_dut4 (
        .clk(clk), .reset(rst_n), .enable(enable), .evt_in(evt_in), .cap_ready(cap_ready),
        .clr_overrun(clr_overrun), .cap_valid(v4), .cap_period(p4), .cap_ovf(ovf4),
        .overrun(ovr4), .busy(busy4)
    );

    timer_capture #(.NBITS(32), .RISING(1'b0)) u_dutf (
        .clk(clk), .reset(rst_n), .enable(enable), .evt_in(evt_in), .cap_ready(cap_ready),
        .clr_overrun(clr_overrun), .cap_valid(vf), .cap_period(pf), .cap_ovf(ovff),
        .overrun(ovrf), .busy(busyf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock; evt_in is always a single-cycle pulse.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        evt_in = 1'b0;
    endtask

    task automatic fire(input int gap);
        while (cyc < t_edge + gap) tick();
        evt_in = 1'b1;
        t_edge = cyc;
    endtask

    task automatic upto(input int off);
        while (cyc < t_edge + off) tick();
    endtask

    initial begin
        rst_n       = 1'b0;
        enable      = 1'b0;
        evt_in      = 1'b0;
        cap_ready   = 1'b0;
        clr_overrun = 1'b0;
        tick();
        tick();
        chk("rst_valid", {31'd0, v32}, 32'd0);
        chk("rst_period", p32, 32'd0);
        chk("rst_ovf", {31'd0, ovf32}, 32'd0);
        chk("rst_overrun", {31'd0, ovr32}, 32'd0);
        chk("rst_busy", {31'd0, busy32}, 32'd0);
        rst_n = 1'b1;
        tick();

        // 1: period 10 with ready held high
        cap_ready = 1'b1;
        enable    = 1'b1;
        tick();
        tick();
        chk("t1_arm_not_busy", {31'd0, busy32}, 32'd0);
        t_edge = cyc;
        fire(0);
        upto(OFF);
        chk("t1_first_nosample", {31'd0, v32}, 32'd0);
        chk("t1_busy", {31'd0, busy32}, 32'd1);
        fire(10);
        upto(OFF - 1);
        chk("t1_pre_latency", {31'd0, v32}, 32'd0);
        upto(OFF);
        chk("t1_valid", {31'd0, v32}, 32'd1);
        chk("t1_period", p32, 32'd10);
        chk("t1_ovf", {31'd0, ovf32}, 32'd0);
        upto(OFF + 1);
        chk("t1_one_cycle", {31'd0, v32}, 32'd0);
        chk("t1_fall_valid", {31'd0, vf}, 32'd1);
        chk("t1_fall_period", pf, 32'd10);
        upto(OFF + 2);
        chk("t1_fall_one_cycle", {31'd0, vf}, 32'd0);
        fire(10);
        upto(OFF);
        chk("t1_period_again", p32, 32'd10);
        chk("t1_n4_period", {28'd0, p4}, 32'd10);
        chk("t1_n4_ovf", {31'd0, ovf4}, 32'd0);

        // 2: 4-bit saturation, then recovery
        fire(20);
        upto(OFF);
        chk("t2_n4_valid", {31'd0, v4}, 32'd1);
        chk("t2_n4_sat_period", {28'd0, p4}, 32'd15);
        chk("t2_n4_sat_ovf", {31'd0, ovf4}, 32'd1);
        chk("t2_n32_period", p32, 32'd20);
        chk("t2_n32_ovf", {31'd0, ovf32}, 32'd0);
        fire(5);
        upto(OFF);
        chk("t2_n4_period5", {28'd0, p4}, 32'd5);
        chk("t2_n4_ovf_clr", {31'd0, ovf4}, 32'd0);
        upto(OFF + 1);

        // 3: consumer stalled, overrun and its clear
        cap_ready = 1'b0;
        fire(8);
        upto(OFF);
        chk("t3_valid", {31'd0, v32}, 32'd1);
        chk("t3_period", p32, 32'd8);
        chk("t3_no_overrun", {31'd0, ovr32}, 32'd0);
        fire(8);
        upto(OFF - 1);
        chk("t3_pre_overrun", {31'd0, ovr32}, 32'd0);
        upto(OFF);
        chk("t3_overrun", {31'd0, ovr32}, 32'd1);
        chk("t3_held_valid", {31'd0, v32}, 32'd1);
        fire(7);
        upto(OFF);
        chk("t3_held_period", p32, 32'd8);
        chk("t3_n4_held_period", {28'd0, p4}, 32'd8);
        clr_overrun = 1'b1;
        tick();
        clr_overrun = 1'b0;
        chk("t3_overrun_cleared", {31'd0, ovr32}, 32'd0);
        fire(8);
        upto(OFF - 1);
        clr_overrun = 1'b1;
        upto(OFF);
        chk("t3_set_beats_clear", {31'd0, ovr32}, 32'd1);
        tick();
        clr_overrun = 1'b0;
        chk("t3_clear_again", {31'd0, ovr32}, 32'd0);

        // 4: acceptance in the same cycle as a new capture
        fire(6);
        upto(OFF - 1);
        cap_ready = 1'b1;
        upto(OFF);
        cap_ready = 1'b0;
        chk("t4_valid", {31'd0, v32}, 32'd1);
        chk("t4_period", p32, 32'd6);
        chk("t4_no_overrun", {31'd0, ovr32}, 32'd0);
        chk("t4_n4_period", {28'd0, p4}, 32'd6);
        upto(OFF + 1);
        chk("t4_held_stable", p32, 32'd6);
        cap_ready = 1'b1;
        tick();
        chk("t4_drained", {31'd0, v32}, 32'd0);

        // 5: abort mid-measurement, re-arm
        chk("t5_busy_meas", {31'd0, busy32}, 32'd1);
        enable = 1'b0;
        tick();
        chk("t5_idle_not_busy", {31'd0, busy32}, 32'd0);
        fire(4);
        upto(OFF + 1);
        chk("t5_idle_ignores_edge", {31'd0, v32}, 32'd0);
        enable = 1'b1;
        tick();
        tick();
        fire(12);
        upto(OFF);
        chk("t5_rearm_nosample", {31'd0, v32}, 32'd0);
        chk("t5_rearm_busy", {31'd0, busy32}, 32'd1);
        fire(7);
        upto(OFF - 1);
        cap_ready = 1'b0;
        upto(OFF);
        chk("t5_period", p32, 32'd7);
        chk("t5_valid", {31'd0, v32}, 32'd1);

        // 6: asynchronous reset with a held sample and overrun set
        fire(9);
        upto(OFF);
        chk("t6_pre_overrun", {31'd0, ovr32}, 32'd1);
        chk("t6_pre_period", p32, 32'd7);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_async_valid", {31'd0, v32}, 32'd0);
        chk("t6_async_period", p32, 32'd0);
        chk("t6_async_overrun", {31'd0, ovr32}, 32'd0);
        chk("t6_async_busy", {31'd0, busy32}, 32'd0);
        chk("t6_async_n4_period", {28'd0, p4}, 32'd0);
        tick();
        rst_n     = 1'b1;
        cap_ready = 1'b1;
        tick();
        tick();
        fire(0);
        upto(OFF);
        chk("t6_first_nosample", {31'd0, v32}, 32'd0);
        fire(10);
        upto(OFF - 1);
        chk("t6_latency_pre", {31'd0, v32}, 32'd0);
        upto(OFF);
        chk("t6_latency_valid", {31'd0, v32}, 32'd1);
        chk("t6_latency_period", p32, 32'd10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
